// File: rtl/cdp_rdma_grp_ctrl_if.sv
// Bundles the register-group control signals of cdp_rdma_grp_ctrl.
// slave is the controller's view; master is the register file / datapath view.
interface cdp_rdma_grp_ctrl_if;
    logic        producer;
    logic        op_en_trigger;
    logic        op_en_wr_data;
    logic        dp2reg_done;
    logic        consumer;
    logic [1:0]  status_0;
    logic [1:0]  status_1;
    logic        reg2dp_op_en;
    logic        dp2reg_d0_op_en;
    logic        dp2reg_d1_op_en;
    logic [1:0]  done_intr;
    logic [31:0] dp2reg_lat_cnt;

    modport slave (
        input  producer, op_en_trigger, op_en_wr_data, dp2reg_done,
        output consumer, status_0, status_1, reg2dp_op_en,
               dp2reg_d0_op_en, dp2reg_d1_op_en, done_intr, dp2reg_lat_cnt
    );

    modport master (
        output producer, op_en_trigger, op_en_wr_data, dp2reg_done,
        input  consumer, status_0, status_1, reg2dp_op_en,
               dp2reg_d0_op_en, dp2reg_d1_op_en, done_intr, dp2reg_lat_cnt
    );
endinterface

// File: rtl/cdp_rdma_grp_ctrl.sv
// Ping-pong register group controller: tracks which group the datapath owns and gates op_en.
// Optional layer cycle counter is built only when CDP_RDMA_LAYER_CYC_CNT_EN is defined.
module cdp_rdma_grp_ctrl (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    cdp_rdma_grp_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        GRP_IDLE    = 2'd0,
        GRP_RUNNING = 2'd1,
        GRP_PENDING = 2'd2
    } grp_status_e;

    logic       opEn0_q, opEn0_d;
    logic       opEn1_q, opEn1_d;
    logic       consumer_q, consumer_d;
    logic       reg2dpOpEn_q, reg2dpOpEn_d;
    logic [1:0] doneIntr_q, doneIntr_d;

    logic qualDone;
    logic setGrp0, setGrp1;
    logic opEnConsumer;

    grp_status_e status0, status1;

    assign qualDone     = bus.dp2reg_done & reg2dpOpEn_q;
    assign setGrp0      = bus.op_en_trigger & bus.op_en_wr_data & ~bus.producer & ~opEn0_q;
    assign setGrp1      = bus.op_en_trigger & bus.op_en_wr_data &  bus.producer & ~opEn1_q;
    assign opEnConsumer = consumer_q ? opEn1_q : opEn0_q;

    // A qualified done always wins over a set on the same group; the clear is what sticks.
    always_comb begin
        opEn0_d      = opEn0_q;
        opEn1_d      = opEn1_q;
        consumer_d   = consumer_q;
        doneIntr_d   = 2'b00;
        reg2dpOpEn_d = opEnConsumer;

        if (setGrp0) opEn0_d = 1'b1;
        if (setGrp1) opEn1_d = 1'b1;

        if (qualDone) begin
            if (consumer_q) opEn1_d = 1'b0;
            else            opEn0_d = 1'b0;
            consumer_d    = ~consumer_q;
            doneIntr_d    = consumer_q ? 2'b10 : 2'b01;
            reg2dpOpEn_d  = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            opEn0_q      <= 1'b0;
            opEn1_q      <= 1'b0;
            consumer_q   <= 1'b0;
            reg2dpOpEn_q <= 1'b0;
            doneIntr_q   <= 2'b00;
        end else begin
            opEn0_q      <= opEn0_d;
            opEn1_q      <= opEn1_d;
            consumer_q   <= consumer_d;
            reg2dpOpEn_q <= reg2dpOpEn_d;
            doneIntr_q   <= doneIntr_d;
        end
    end

    always_comb begin
        status0 = GRP_IDLE;
        status1 = GRP_IDLE;
        if (opEn0_q) status0 = consumer_q ? GRP_PENDING : GRP_RUNNING;
        if (opEn1_q) status1 = consumer_q ? GRP_RUNNING : GRP_PENDING;
    end

`ifdef CDP_RDMA_LAYER_CYC_CNT_EN
    logic [31:0] latCnt_q, latCnt_d;

    // Restart on the enable rise, count enabled cycles, saturate, and hold once enable drops.
    always_comb begin
        latCnt_d = latCnt_q;
        if (reg2dpOpEn_d & ~reg2dpOpEn_q)
            latCnt_d = 32'd0;
        else if (reg2dpOpEn_q && latCnt_q != 32'hFFFF_FFFF)
            latCnt_d = latCnt_q + 32'd1;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) latCnt_q <= 32'd0;
        else                  latCnt_q <= latCnt_d;
    end

    assign bus.dp2reg_lat_cnt = latCnt_q;
`else
    assign bus.dp2reg_lat_cnt = 32'd0;
`endif

    assign bus.consumer        = consumer_q;
    assign bus.status_0        = status0;
    assign bus.status_1        = status1;
    assign bus.reg2dp_op_en    = reg2dpOpEn_q;
    assign bus.dp2reg_d0_op_en = opEn0_q;
    assign bus.dp2reg_d1_op_en = opEn1_q;
    assign bus.done_intr       = doneIntr_q;

endmodule

// File: tb/tb_cdp_rdma_grp_ctrl.sv
// Testbench for cdp_rdma_grp_ctrl: directed scenarios plus random traffic against a group-ownership model.
// Latency counter expectations follow CDP_RDMA_LAYER_CYC_CNT_EN.
module tb_cdp_rdma_grp_ctrl;

    logic nvdla_core_clk;
    logic nvdla_core_rstn;

    cdp_rdma_grp_ctrl_if bus ();

    cdp_rdma_grp_ctrl dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .bus             (bus)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which groups are armed, who owns the datapath, and layer bookkeeping.
    bit        mArmed [2];
    int        mOwner;
    bit        mEnable;
    bit [1:0]  mIntr;
    longint    mLat;

    function automatic void modelReset();
        mArmed[0] = 0;
        mArmed[1] = 0;
        mOwner    = 0;
        mEnable   = 0;
        mIntr     = 2'b00;
        mLat      = 0;
    endfunction

    function automatic void modelCycle(int prod, bit trig, bit wr, bit done);
        bit finished;
        bit wasEnabled;
        finished   = done && mEnable;
        wasEnabled = mEnable;
        mIntr      = 2'b00;
        mEnable    = finished ? 1'b0 : mArmed[mOwner];
        if (trig && wr && !mArmed[prod]) mArmed[prod] = 1;
        if (finished) begin
            mArmed[mOwner] = 0;
            mIntr[mOwner]  = 1'b1;
            mOwner         = 1 - mOwner;
        end
        if (!wasEnabled && mEnable) mLat = 0;
        else if (wasEnabled && mLat < 64'hFFFF_FFFF) mLat = mLat + 1;
    endfunction

    function automatic logic [1:0] expStatus(int g);
        if (!mArmed[g]) return 2'd0;
        return (mOwner == g) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [31:0] expLat();
`ifdef CDP_RDMA_LAYER_CYC_CNT_EN
        return mLat[31:0];
`else
        return 32'd0;
`endif
    endfunction

    task automatic checkValue(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(string tag);
        checkValue({tag, ".consumer"}, 32'(bus.consumer),        32'(mOwner));
        checkValue({tag, ".status_0"}, 32'(bus.status_0),        32'(expStatus(0)));
        checkValue({tag, ".status_1"}, 32'(bus.status_1),        32'(expStatus(1)));
        checkValue({tag, ".op_en"},    32'(bus.reg2dp_op_en),    32'(mEnable));
        checkValue({tag, ".d0_op_en"}, 32'(bus.dp2reg_d0_op_en), 32'(mArmed[0]));
        checkValue({tag, ".d1_op_en"}, 32'(bus.dp2reg_d1_op_en), 32'(mArmed[1]));
        checkValue({tag, ".intr"},     32'(bus.done_intr),       32'(mIntr));
        checkValue({tag, ".lat"},      bus.dp2reg_lat_cnt,       expLat());
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic applyStimulus(int prod, bit trig, bit wr, bit done, string tag);
        bus.producer      = prod[0];
        bus.op_en_trigger = trig;
        bus.op_en_wr_data = wr;
        bus.dp2reg_done   = done;
        @(posedge nvdla_core_clk);
        modelCycle(prod, trig, wr, done);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        bus.producer      = 1'b0;
        bus.op_en_trigger = 1'b0;
        bus.op_en_wr_data = 1'b0;
        bus.dp2reg_done   = 1'b0;
        nvdla_core_rstn   = 1'b0;
        modelReset();
        repeat (2) @(posedge nvdla_core_clk);
        #1;
        checkOutput("reset");
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        @(posedge nvdla_core_clk);
        #1;
        checkOutput("release");

        // Group 0 programmed and started
        applyStimulus(0, 1, 1, 0, "g0_set");
        checkValue("g0_running", 32'(bus.status_0), 32'd1);
        checkValue("g0_en_latency", 32'(bus.reg2dp_op_en), 32'd0);
        applyStimulus(0, 0, 0, 0, "g0_en");
        checkValue("g0_en_high", 32'(bus.reg2dp_op_en), 32'd1);
        checkValue("g1_idle", 32'(bus.status_1), 32'd0);

        // Software cannot clear or re-arm a running group
        applyStimulus(0, 1, 0, 0, "g0_wr0");
        applyStimulus(0, 1, 1, 0, "g0_rewr");
        checkValue("g0_still_running", 32'(bus.status_0), 32'd1);

        // Queue group 1 behind group 0, then finish group 0
        applyStimulus(1, 1, 1, 0, "g1_set");
        checkValue("g1_pending", 32'(bus.status_1), 32'd2);
        applyStimulus(0, 0, 0, 1, "g0_done");
        checkValue("swap_consumer", 32'(bus.consumer), 32'd1);
        checkValue("swap_intr", 32'(bus.done_intr), 32'd1);
        checkValue("swap_en_low", 32'(bus.reg2dp_op_en), 32'd0);
        checkValue("g1_running", 32'(bus.status_1), 32'd1);
        applyStimulus(0, 0, 0, 0, "g1_en");
        checkValue("swap_en_high", 32'(bus.reg2dp_op_en), 32'd1);

        // Set on the running group coincident with its done: clear wins
        applyStimulus(1, 1, 1, 1, "g1_set_done");
        checkValue("g1_cleared", 32'(bus.status_1), 32'd0);
        // Done ignored while enable is low
        applyStimulus(0, 0, 0, 1, "unqual_done");
        applyStimulus(1, 0, 0, 1, "unqual_done2");

        // Group 0 layer of exactly 100 enabled cycles, with group 1 set on the done cycle
        applyStimulus(0, 1, 1, 0, "lat_set");
        applyStimulus(0, 0, 0, 0, "lat_rise");
        for (int i = 0; i < 99; i++) applyStimulus(0, 0, 0, 0, "lat_run");
        applyStimulus(1, 1, 1, 1, "lat_done_set");
`ifdef CDP_RDMA_LAYER_CYC_CNT_EN
        checkValue("lat_100", bus.dp2reg_lat_cnt, 32'd100);
`else
        checkValue("lat_tied", bus.dp2reg_lat_cnt, 32'd0);
`endif
        checkValue("overlap_running", 32'(bus.status_1), 32'd1);
        checkValue("overlap_en_low", 32'(bus.reg2dp_op_en), 32'd0);
        applyStimulus(0, 0, 0, 0, "lat_next_rise");
        checkValue("overlap_en_high", 32'(bus.reg2dp_op_en), 32'd1);

        // Arm group 0 as pending, then reset mid-layer
        applyStimulus(0, 1, 1, 0, "pend_set");
        applyStimulus(0, 0, 0, 0, "pend_run");
        #2;
        nvdla_core_rstn = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        bus.dp2reg_done = 1'b1;
        @(posedge nvdla_core_clk);
        #1;
        checkOutput("in_reset");
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        applyStimulus(0, 0, 0, 1, "post_reset_done");
        checkValue("no_intr_after_reset", 32'(bus.done_intr), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(int'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 5) == 0),
                          "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
